// File: rtl/data_boot_loader_pkg.sv
// Shared definitions for the byte-stream data memory boot loader.
package data_boot_loader_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_DATA,
        S_WRITE,
        S_CSUM,
        S_DONE,
        S_ERR
    } state_e;

    localparam int BYTES_PER_WORD = 4;

endpackage

// File: rtl/data_boot_loader_asm.sv
// Packs stream bytes MSB-first into boot words and keeps the running XOR checksum.
module boot_word_assembler
    import data_boot_loader_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  clr_i,
    input  logic                  byte_vld_i,
    input  logic [7:0]            byte_i,
    output logic [DATA_WIDTH-1:0] word_o,
    output logic                  word_valid_o,
    output logic [7:0]            xor_o
);

    localparam int CW = $clog2(BYTES_PER_WORD);

    logic [DATA_WIDTH-1:0] word_q;
    logic [CW-1:0]         cnt_q;
    logic [7:0]            xor_q;

    // word_o already contains the incoming byte so the top can latch it on the 4th beat
    assign word_o       = {word_q[DATA_WIDTH-9:0], byte_i};
    assign word_valid_o = byte_vld_i && (cnt_q == CW'(BYTES_PER_WORD - 1));
    assign xor_o        = xor_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            word_q <= '0;
            cnt_q  <= '0;
            xor_q  <= '0;
        end else if (clr_i) begin
            word_q <= '0;
            cnt_q  <= '0;
            xor_q  <= '0;
        end else if (byte_vld_i) begin
            word_q <= word_o;
            cnt_q  <= cnt_q + CW'(1);
            xor_q  <= xor_q ^ byte_i;
        end
    end

endmodule

// File: rtl/data_boot_loader.sv
// Boot loader: receives a framed image (count, words, XOR checksum) and writes
// it to the data memory boot port, holding the CPU in reset until verified.
module data_boot_loader
    import data_boot_loader_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 8,
    parameter int                    DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  start,
    input  logic [7:0]            in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [ADDR_WIDTH-1:0] boot_daddr,
    output logic [DATA_WIDTH-1:0] boot_ddata,
    output logic                  boot_dwe,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic                  cpu_resetn
);

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [7:0]            wcnt_q, wcnt_d;
    logic [7:0]            n_q, n_d;
    logic                  dwe_q, dwe_d;
    logic [ADDR_WIDTH-1:0] daddr_q, daddr_d;
    logic [DATA_WIDTH-1:0] ddata_q, ddata_d;
    logic                  busy_q, done_q, error_q, cpur_q;

    logic                  clr, xfer, word_valid;
    logic [DATA_WIDTH-1:0] word;
    logic [7:0]            csum;

    assign in_ready = (state_q == S_HDR) || (state_q == S_DATA) || (state_q == S_CSUM);
    assign xfer     = in_valid && in_ready;

    boot_word_assembler #(.DATA_WIDTH(DATA_WIDTH)) u_asm (
        .clk          (clk),
        .resetn       (resetn),
        .clr_i        (clr),
        .byte_vld_i   (xfer && (state_q == S_DATA)),
        .byte_i       (in_data),
        .word_o       (word),
        .word_valid_o (word_valid),
        .xor_o        (csum)
    );

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wcnt_d  = wcnt_q;
        n_d     = n_q;
        dwe_d   = 1'b0;
        daddr_d = daddr_q;
        ddata_d = ddata_q;
        clr     = 1'b0;
        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) begin
                    state_d = S_HDR;
                    clr     = 1'b1;
                    addr_d  = BASE_ADDR;
                    wcnt_d  = '0;
                end
            end
            S_HDR: begin
                if (xfer) begin
                    n_d     = in_data;
                    state_d = (in_data == 8'd0) ? S_CSUM : S_DATA;
                end
            end
            S_DATA: begin
                // Boot port is registered, so it is loaded on entry to WRITE
                if (word_valid) begin
                    state_d = S_WRITE;
                    dwe_d   = 1'b1;
                    daddr_d = addr_q;
                    ddata_d = word;
                end
            end
            S_WRITE: begin
                addr_d  = addr_q + ADDR_WIDTH'(1);
                wcnt_d  = wcnt_q + 8'd1;
                state_d = (wcnt_d == n_q) ? S_CSUM : S_DATA;
            end
            S_CSUM: begin
                if (xfer) state_d = (in_data == csum) ? S_DONE : S_ERR;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state_q <= S_IDLE;
        else         state_q <= state_d;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            addr_q  <= '0;
            wcnt_q  <= '0;
            n_q     <= '0;
            dwe_q   <= 1'b0;
            daddr_q <= '0;
            ddata_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
            cpur_q  <= 1'b0;
        end else begin
            addr_q  <= addr_d;
            wcnt_q  <= wcnt_d;
            n_q     <= n_d;
            dwe_q   <= dwe_d;
            daddr_q <= daddr_d;
            ddata_q <= ddata_d;
            busy_q  <= (state_d == S_HDR) || (state_d == S_DATA) ||
                       (state_d == S_WRITE) || (state_d == S_CSUM);
            done_q  <= (state_d == S_DONE);
            error_q <= (state_d == S_ERR);
            cpur_q  <= (state_d == S_DONE);
        end
    end

    assign boot_daddr = daddr_q;
    assign boot_ddata = ddata_q;
    assign boot_dwe   = dwe_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign error      = error_q;
    assign cpu_resetn = cpur_q;

endmodule

// File: tb/tb_data_boot_loader.sv
// Directed bench: frame table applied to two loaders (base 0x00 and 0xFE) plus reset corner cases.
module tb_data_boot_loader;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       start = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;

    logic        rdy0, dwe0, busy0, done0, err0, cpur0;
    logic [7:0]  daddr0;
    logic [31:0] ddata0;
    logic        rdy1, dwe1, busy1, done1, err1, cpur1;
    logic [7:0]  daddr1;
    logic [31:0] ddata1;

    always #5 clk = ~clk;

    data_boot_loader #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .BASE_ADDR(8'h00)) dut0 (
        .clk(clk), .resetn(resetn), .start(start), .in_data(in_data), .in_valid(in_valid),
        .in_ready(rdy0), .boot_daddr(daddr0), .boot_ddata(ddata0), .boot_dwe(dwe0),
        .busy(busy0), .done(done0), .error(err0), .cpu_resetn(cpur0));

    data_boot_loader #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .BASE_ADDR(8'hFE)) dut1 (
        .clk(clk), .resetn(resetn), .start(start), .in_data(in_data), .in_valid(in_valid),
        .in_ready(rdy1), .boot_daddr(daddr1), .boot_ddata(ddata1), .boot_dwe(dwe1),
        .busy(busy1), .done(done1), .error(err1), .cpu_resetn(cpur1));

    typedef struct packed {
        logic [7:0]  a;
        logic [31:0] d;
        logic        rdy;
    } wr_t;

    wr_t q0[$];
    wr_t q1[$];

    always @(negedge clk) begin
        if (dwe0) q0.push_back({daddr0, ddata0, rdy0});
        if (dwe1) q1.push_back({daddr1, ddata1, rdy1});
    end

    typedef struct {
        int               n;
        logic [3:0][31:0] w;
        logic [7:0]       csum;
        bit               ok;
        bit               gaps;
    } vec_t;

    vec_t vt[7];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input int n, input logic [31:0] w0, input logic [31:0] w1,
                                input logic [31:0] w2, input logic [7:0] cs, input bit ok,
                                input bit gaps);
        vec_t v;
        v.n = n; v.w[0] = w0; v.w[1] = w1; v.w[2] = w2; v.w[3] = '0;
        v.csum = cs; v.ok = ok; v.gaps = gaps;
        return v;
    endfunction

    // Caller is always #1 after a rising edge; returns the same way.
    task automatic send_byte(input logic [7:0] b, input int gap);
        bit got = 1'b0;
        repeat (gap) begin @(posedge clk); #1; end
        in_valid = 1'b1;
        in_data  = b;
        for (int k = 0; k < 50; k++) begin
            if (rdy0) begin
                @(posedge clk); #1;
                got = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        if (!got) chk("byte_accept_timeout", 64'd0, 64'd1);
    endtask

    task automatic start_load();
        // in_valid rides along with start: the byte must not be consumed outside HDR
        in_valid = 1'b1;
        in_data  = 8'h00;
        start    = 1'b1;
        @(posedge clk); #1;
        start    = 1'b0;
        in_valid = 1'b0;
        chk("after_start_busy", busy0, 1);
        chk("after_start_flags", {done0, err0, cpur0}, 3'b000);
        chk("after_start_in_ready", rdy0, 1);
    endtask

    task automatic run_frame(input vec_t v, input int idx);
        int b0 = q0.size();
        int b1 = q1.size();
        logic [7:0] nb;
        start_load();
        nb = v.n[7:0];
        send_byte(nb, 0);
        for (int i = 0; i < v.n; i++) begin
            for (int b = 0; b < 4; b++) begin
                int gap = v.gaps ? int'($urandom_range(0, 3)) : 0;
                if (v.gaps && i == 0 && b == 2) begin
                    start = 1'b1;
                    @(posedge clk); #1;
                    start = 1'b0;
                end
                send_byte(v.w[i][31-8*b -: 8], gap);
            end
        end
        send_byte(v.csum, v.gaps ? 2 : 0);
        @(posedge clk); #1;
        chk($sformatf("v%0d_done", idx), {done0, err0, cpur0, busy0}, {v.ok, !v.ok, v.ok, 1'b0});
        chk($sformatf("v%0d_base_fe_done", idx), {done1, err1}, {v.ok, !v.ok});
        chk($sformatf("v%0d_nwrites", idx), q0.size() - b0, v.n);
        chk($sformatf("v%0d_nwrites_fe", idx), q1.size() - b1, v.n);
        for (int i = 0; i < v.n && (b0 + i) < q0.size() && (b1 + i) < q1.size(); i++) begin
            logic [7:0] ea0 = 8'h00 + i[7:0];
            logic [7:0] ea1 = 8'hFE + i[7:0];
            chk($sformatf("v%0d_w%0d_addr", idx, i), q0[b0+i].a, ea0);
            chk($sformatf("v%0d_w%0d_data", idx, i), q0[b0+i].d, v.w[i]);
            chk($sformatf("v%0d_w%0d_rdy_in_write", idx, i), q0[b0+i].rdy, 0);
            chk($sformatf("v%0d_w%0d_addr_fe", idx, i), q1[b1+i].a, ea1);
            chk($sformatf("v%0d_w%0d_data_fe", idx, i), q1[b1+i].d, v.w[i]);
        end
    endtask

    task automatic chk_all_zero(input string name);
        chk(name, {rdy0, dwe0, busy0, done0, err0, cpur0, daddr0, ddata0}, 64'd0);
    endtask

    initial begin
        int b0;
        // XOR of 11 22 33 44 A5 A5 5A 5A is 0x44
        vt[0] = mk(2, 32'h11223344, 32'hA5A55A5A, 32'h0, 8'h44, 1'b1, 1'b0);
        vt[1] = mk(2, 32'h11223344, 32'hA5A55A5A, 32'h0, 8'h01, 1'b0, 1'b0);
        vt[2] = mk(0, 32'h0, 32'h0, 32'h0, 8'h00, 1'b1, 1'b0);
        vt[3] = mk(0, 32'h0, 32'h0, 32'h0, 8'h7F, 1'b0, 1'b0);
        // 04 ^ 22 ^ 00 = 0x26
        vt[4] = mk(3, 32'h01020304, 32'hDEADBEEF, 32'h00FF00FF, 8'h26, 1'b1, 1'b0);
        vt[5] = mk(2, 32'h11223344, 32'hA5A55A5A, 32'h0, 8'h44, 1'b1, 1'b1);
        vt[6] = mk(1, 32'hCAFEF00D, 32'h0, 32'h0, 8'hC9, 1'b1, 1'b1);

        repeat (3) @(posedge clk);
        #1;
        chk_all_zero("reset_outputs");
        resetn = 1'b1;
        @(posedge clk); #1;
        chk_all_zero("idle_outputs");

        for (int i = 0; i < 7; i++) run_frame(vt[i], i);

        // Abort mid-word: reset after two data bytes of word 1
        b0 = q0.size();
        start_load();
        send_byte(8'd2, 0);
        send_byte(8'h11, 0);
        send_byte(8'h22, 0);
        resetn = 1'b0;
        #1;
        chk_all_zero("midload_reset_outputs");
        @(posedge clk); #1;
        chk("midload_no_write", q0.size() - b0, 0);
        resetn = 1'b1;
        @(posedge clk); #1;
        chk_all_zero("after_release_idle");
        run_frame(vt[0], 10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
